div_pipe: RTL
=============

Name: div_pipe

Overview:
- Parametrised pipelined integer divider; successor to the fixed unsigned restoring divider.
- Adds per-operation signed/unsigned mode, a valid/ready handshake with backpressure, and a configurable number of quotient bits per register stage.
- Adds divide-by-zero and signed-overflow flags, and an opaque tag carried alongside each operation.
- Sits between fixed-point datapath blocks that need division with flow control.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- BITS_PER_STAGE, 1, quotient bits resolved per pipeline register stage. Must divide WIDTH; elaboration error otherwise.
- TAG_WIDTH, 4, width of the passthrough tag; must be ≥ 1.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- in_tag  input  TAG_WIDTH  opaque; returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  divisor was 0.
- overflow  output  1  signed most-negative / -1.
- out_tag  output  TAG_WIDTH  tag of this result.

Behaviour:
- Stages: N = WIDTH/BITS_PER_STAGE.
  - Pipeline is: prep stage → N iteration stages → output stage.
  - Each stage has a valid bit.
  - Latency from acceptance to out_valid is N+2 cycles when there is no stall.
- Global stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 0, every stage, valid bit and output holds its value.
  - Bubbles are not compressed; this is a deliberate simplicity trade-off.
- Throughput: one operation per cycle while out_ready = 1.
- Prep stage:
  - Registers the absolute values of the operands (signed mode, negative operand → two's-complement negate; the most-negative value maps to 2^(WIDTH-1) unsigned).
  - Also registers: neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend), zero = (divisor == 0), ovf = signed && dividend == 100…0 && divisor == all ones, and the tag.
- Iteration stages:
  - Each performs BITS_PER_STAGE restoring shift/subtract steps on a 2·WIDTH partial-remainder/quotient register.
  - The magnitude divisor and flags are carried alongside.
  - Arithmetic is WIDTH+1 bits so the subtract borrow is exact.
- Output stage: applies the sign correction and registers all outputs.
  - Normal signed result: quotient truncates toward zero; remainder takes the dividend's sign. The identity dividend = quotient·divisor + remainder holds.
  - div_by_zero: quotient = all ones and remainder = the original dividend, in both modes; overflow = 0.
  - overflow (signed only): quotient = 100…0, remainder = 0, div_by_zero = 0.
  - Flags are meaningful only while out_valid = 1.
- Reset, while asserted:
  - All valid bits and out_valid go to 0.
  - quotient, remainder, out_tag, div_by_zero and overflow go to 0.
  - in_ready reads 1, since out_valid = 0.
  - In-flight operations are discarded with no partial output.
  - First acceptance is possible on the first rising edge after deassertion.
- Simultaneous events:
  - An input accept and an output drain in the same cycle are both taken; the pipeline shifts by one.
  - out_ready is a don't-care when out_valid = 0.
- out_valid and the data outputs are stable while out_valid && !out_ready.
- There is no combinational path from in_valid to in_ready; in_ready depends only on out_valid and out_ready.

Test Plan:
- Unsigned example (WIDTH=8, BITS_PER_STAGE=2, N=4): dividend 200, divisor 7, in_signed 0, tag 5 → 6 cycles later out_valid=1, quotient 28, remainder 4, out_tag 5, flags 0.
- Signed remainder signs (WIDTH=8): -7/2 → q=-3 (0xFD), r=-1 (0xFF). 7/-2 → q=-3, r=1. -7/-2 → q=3, r=-1.
- Corner cases (WIDTH=8):
  - Signed -128/-1 → q=0x80, r=0, overflow=1.
  - Unsigned 0x80/0xFF → q=0, r=0x80, overflow=0.
  - Any /0 (e.g. 0x35/0, both modes) → q=0xFF, r=0x35, div_by_zero=1.
- Backpressure:
  - Stream 10 back-to-back operations with out_ready low on cycles 7–9.
  - Required: in_ready=0 during those cycles; no result lost, duplicated or reordered (checked via tag sequence); outputs stable while stalled.
- Reset mid-flight: assert reset with 3 operations in flight → out_valid=0 and all outputs 0 immediately (asynchronous); after release, new operation 100/10 → q=10, r=0 after N+2 cycles, with no stale results.
- Exhaustive sweep across all configurations:
  - Configurations: WIDTH=8 with BITS_PER_STAGE ∈ {1,2,4,8}.
  - Stimulus: all dividend/divisor pairs in both modes, with random out_ready.
  - Required: every result matches a reference model (truncating division plus the rules above).

Source files
------------

// File: rtl/div_pipe_if.sv
// div_pipe_if: handshake and data bundle for the pipelined divider.
//   Request side : in_valid, in_ready, in_signed, dividend, divisor, in_tag
//   Response side: out_valid, out_ready, quotient, remainder,
//                  div_by_zero, overflow, out_tag
//   modport slave  - the divider's view
//   modport master - the requester / consumer view
interface div_pipe_if #(
    parameter int WIDTH     = 16,
    parameter int TAG_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;
    logic [TAG_WIDTH-1:0] out_tag;

    modport slave (
        input  in_valid, in_signed, dividend, divisor, in_tag, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, out_tag
    );

    modport master (
        output in_valid, in_signed, dividend, divisor, in_tag, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, out_tag
    );
endinterface

// File: rtl/div_pipe.sv
// div_pipe: pipelined restoring integer divider with valid/ready flow control.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears all valid bits and outputs
//   bus   - div_pipe_if.slave: request (in_*/dividend/divisor), response
//           (out_*/quotient/remainder/div_by_zero/overflow)
// Pipeline: prep stage -> WIDTH/BITS_PER_STAGE iteration stages -> output
// stage. A single global advance signal stalls everything when the output is
// held, so latency is N+2 cycles without stalls and bubbles are kept.
module div_pipe #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_WIDTH      = 4
) (
    input logic       clk,
    input logic       reset,
    div_pipe_if.slave bus
);
    if (WIDTH < 2) begin : g_bad_width
        $error("div_pipe: WIDTH must be >= 2");
    end else if (BITS_PER_STAGE < 1 || (WIDTH % BITS_PER_STAGE) != 0) begin : g_bad_bps
        $error("div_pipe: BITS_PER_STAGE must divide WIDTH");
    end else if (TAG_WIDTH < 1) begin : g_bad_tag
        $error("div_pipe: TAG_WIDTH must be >= 1");
    end

    localparam int unsigned N   = WIDTH / BITS_PER_STAGE;
    localparam int unsigned BPS = BITS_PER_STAGE;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // pr holds {partial remainder, quotient/dividend bits} in magnitude form.
    typedef struct packed {
        logic                 valid;
        logic [2*WIDTH-1:0]   pr;
        logic [WIDTH-1:0]     dvs;
        logic                 neg_q;
        logic                 neg_r;
        logic                 zero;
        logic                 ovf;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    // Index 0 is the prep stage, 1..N are the iteration stages.
    stage_t stg_q [0:N];
    stage_t stg_d [0:N];

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 div_by_zero_q, div_by_zero_d;
    logic                 overflow_q, overflow_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    logic                 advance;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     r_mag;

    function automatic logic [WIDTH-1:0] magnitude(input logic sgn, input logic [WIDTH-1:0] v);
        // Negating the most-negative value wraps to itself, which reads as
        // 2^(WIDTH-1) when treated as unsigned.
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // One restoring step; the compare is done WIDTH+2 bits wide so the borrow
    // of the (WIDTH+1)-bit shifted remainder minus divisor is exact.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] pr,
                                                    input logic [WIDTH-1:0]   dvs);
        logic [WIDTH:0]   r_ext;
        logic [WIDTH+1:0] diff;
        r_ext = pr[2*WIDTH-1:WIDTH-1];
        diff  = {1'b0, r_ext} - {2'b00, dvs};
        if (diff[WIDTH+1]) begin
            return {r_ext[WIDTH-1:0], pr[WIDTH-2:0], 1'b0};
        end
        return {diff[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
    endfunction

    always_comb begin
        advance = !out_valid_q || bus.out_ready;
    end

    always_comb begin
        for (int unsigned i = 0; i <= N; i++) begin
            stg_d[i] = stg_q[i];
        end
        if (advance) begin
            stg_d[0].valid = bus.in_valid;
            stg_d[0].pr    = (2*WIDTH)'(magnitude(bus.in_signed, bus.dividend));
            stg_d[0].dvs   = magnitude(bus.in_signed, bus.divisor);
            stg_d[0].neg_q = bus.in_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            stg_d[0].neg_r = bus.in_signed && bus.dividend[WIDTH-1];
            stg_d[0].zero  = (bus.divisor == '0);
            stg_d[0].ovf   = bus.in_signed && (bus.dividend == MOST_NEG) && (&bus.divisor);
            stg_d[0].tag   = bus.in_tag;
            for (int unsigned i = 1; i <= N; i++) begin
                stg_d[i] = stg_q[i-1];
                for (int unsigned k = 0; k < BPS; k++) begin
                    stg_d[i].pr = div_step(stg_d[i].pr, stg_d[i].dvs);
                end
            end
        end
    end

    always_comb begin
        q_mag         = stg_q[N].pr[WIDTH-1:0];
        r_mag         = stg_q[N].pr[2*WIDTH-1:WIDTH];
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        out_tag_d     = out_tag_q;
        if (advance) begin
            out_valid_d = stg_q[N].valid;
            out_tag_d   = stg_q[N].tag;
            if (stg_q[N].zero) begin
                // Dividing by zero subtracts nothing, so every quotient bit is
                // set and the magnitude remainder is |dividend|; restoring its
                // sign gives back the original dividend in both modes.
                quotient_d    = '1;
                remainder_d   = stg_q[N].neg_r ? -r_mag : r_mag;
                div_by_zero_d = 1'b1;
                overflow_d    = 1'b0;
            end else if (stg_q[N].ovf) begin
                quotient_d    = MOST_NEG;
                remainder_d   = '0;
                div_by_zero_d = 1'b0;
                overflow_d    = 1'b1;
            end else begin
                quotient_d    = stg_q[N].neg_q ? -q_mag : q_mag;
                remainder_d   = stg_q[N].neg_r ? -r_mag : r_mag;
                div_by_zero_d = 1'b0;
                overflow_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= N; i++) begin
                stg_q[i] <= '0;
            end
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            out_tag_q     <= '0;
        end else begin
            for (int unsigned i = 0; i <= N; i++) begin
                stg_q[i] <= stg_d[i];
            end
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
            out_tag_q     <= out_tag_d;
        end
    end

    always_comb begin
        bus.in_ready    = advance;
        bus.out_valid   = out_valid_q;
        bus.quotient    = quotient_q;
        bus.remainder   = remainder_q;
        bus.div_by_zero = div_by_zero_q;
        bus.overflow    = overflow_q;
        bus.out_tag     = out_tag_q;
    end
endmodule
